aer_array_reset_seq: RTL and testbench

- Sits directly downstream of the AER reset timer. Consumes its active-low reset request and turns it into a clean, minimum-width reset pulse for the pixel array.
- Sequences that pulse safely against the AER req/ack handshake:
  - drains any in-flight event;
  - holds off new events during reset and settling;
  - counts completed resets and flags drain timeouts.
- Single clock domain, shared with the timer and the AER readout.

---
 rtl/aer_array_reset_seq_if.sv | 23 ++
 rtl/aer_array_reset_seq.sv | 145 ++++++++++++++
 tb/tb_aer_array_reset_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/aer_array_reset_seq_if.sv
// AER reset-sequencer handshake bundle: the reset request from the timer,
// the AER req/ack pair, and the array reset and readout hold-off outputs.
`timescale 1ns/1ps
interface aer_array_reset_seq_if;
    logic rst_req_n;
    logic aer_req;
    logic aer_ack;
    logic array_rst_n;
    logic readout_hold;
    logic busy;

    // Environment side: reset timer, pixel array and readout
    modport master (
        output rst_req_n, aer_req, aer_ack,
        input  array_rst_n, readout_hold, busy
    );

    // Sequencer side
    modport slave (
        input  rst_req_n, aer_req, aer_ack,
        output array_rst_n, readout_hold, busy
    );
endinterface

// File: rtl/aer_array_reset_seq.sv
// AER pixel-array reset sequencer. Drains the AER handshake, drives a
// minimum-width active-low array reset, applies a post-reset guard time,
// and keeps completed-reset and drain-timeout statistics.
`timescale 1ns/1ps
module aer_array_reset_seq #(
    parameter int PW_WIDTH  = 8,
    parameter int TMO_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    aer_array_reset_seq_if.slave aer,
    input  logic [PW_WIDTH-1:0]  min_pulse,
    input  logic [PW_WIDTH-1:0]  settle,
    input  logic [TMO_WIDTH-1:0] drain_tmo,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] rst_count,
    output logic                 tmo_flag
);
    typedef enum logic [1:0] {IDLE, DRAIN, ASSERT, SETTLE} state_t;

    state_t               state, state_nx;
    logic [PW_WIDTH-1:0]  pulse_cnt, settle_cnt;
    logic [TMO_WIDTH-1:0] tmo_cnt;
    logic [PW_WIDTH-1:0]  mp_cfg, st_cfg;
    logic [TMO_WIDTH-1:0] tmo_cfg;
    logic [PW_WIDTH-1:0]  mp_lim, st_lim;
    logic [TMO_WIDTH-1:0] tmo_lim;
    logic                 pend;
    logic                 drain_idle, tmo_hit, pulse_done, settle_done;
    logic                 seq_done, tmo_evt;

    // Counters hold cycles already spent in the state, so "this cycle
    // completes N cycles" is cnt >= N-1. Limits never underflow: a zero
    // min_pulse behaves as 1, and the zero cases of settle/drain_tmo are
    // excluded before their limit is used.
    assign mp_lim      = (mp_cfg == '0) ? '0 : mp_cfg - 1'b1;
    assign st_lim      = st_cfg - 1'b1;
    assign tmo_lim     = tmo_cfg - 1'b1;
    assign drain_idle  = !aer.aer_req && !aer.aer_ack;
    assign tmo_hit     = (tmo_cfg != '0) && (tmo_cnt >= tmo_lim);
    assign pulse_done  = pulse_cnt >= mp_lim;
    assign settle_done = settle_cnt >= st_lim;

    // Next-state logic and one-cycle sequence/timeout events
    always_comb begin
        state_nx = state;
        seq_done = 1'b0;
        tmo_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (!aer.rst_req_n || pend) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_idle) begin
                    state_nx = ASSERT;
                end else if (tmo_hit) begin
                    state_nx = ASSERT;
                    tmo_evt  = 1'b1;
                end
            end
            ASSERT: begin
                // A request still held low stretches the pulse
                if (pulse_done && aer.rst_req_n) begin
                    if (st_cfg == '0) begin
                        state_nx = IDLE;
                        seq_done = 1'b1;
                    end else begin
                        state_nx = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nx = IDLE;
                    seq_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, per-state counters, config snapshots and pending request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pulse_cnt  <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            mp_cfg     <= '0;
            st_cfg     <= '0;
            tmo_cfg    <= '0;
            pend       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                pulse_cnt  <= '0;
                settle_cnt <= '0;
                tmo_cnt    <= '0;
            end else begin
                if (state == DRAIN  && tmo_cnt    != '1) tmo_cnt    <= tmo_cnt + 1'b1;
                if (state == ASSERT && pulse_cnt  != '1) pulse_cnt  <= pulse_cnt + 1'b1;
                if (state == SETTLE && settle_cnt != '1) settle_cnt <= settle_cnt + 1'b1;
            end
            // Pulse width and drain timeout are fixed once a sequence starts;
            // the guard time is fixed once the pulse starts, which also
            // decides whether ASSERT skips SETTLE entirely.
            if (state == IDLE && state_nx == DRAIN) begin
                mp_cfg  <= min_pulse;
                tmo_cfg <= drain_tmo;
            end
            if (state == DRAIN && state_nx == ASSERT) st_cfg <= settle;
            // A request seen during the guard time restarts right after IDLE
            if (state == SETTLE && !aer.rst_req_n) pend <= 1'b1;
            else if (state == IDLE && state_nx == DRAIN) pend <= 1'b0;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aer.array_rst_n  <= 1'b1;
            aer.readout_hold <= 1'b0;
            aer.busy         <= 1'b0;
        end else begin
            aer.array_rst_n  <= (state_nx != ASSERT);
            aer.readout_hold <= (state_nx != IDLE);
            aer.busy         <= (state_nx != IDLE);
        end
    end

    // Statistics; a clear beats a coincident increment or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_count <= '0;
            tmo_flag  <= 1'b0;
        end else if (clr_stats) begin
            rst_count <= '0;
            tmo_flag  <= 1'b0;
        end else begin
            if (seq_done && rst_count != '1) rst_count <= rst_count + 1'b1;
            if (tmo_evt) tmo_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aer_array_reset_seq.sv
// Directed bench for the AER array reset sequencer (CNT_WIDTH=2 so the
// saturating counter is reachable).
`timescale 1ns/1ps
module tb_aer_array_reset_seq;
    localparam int PW = 8, TW = 8, CW = 2;

    logic          clk, rst;
    logic [PW-1:0] min_pulse, settle;
    logic [TW-1:0] drain_tmo;
    logic          clr_stats;
    logic [CW-1:0] rst_count;
    logic          tmo_flag;
    int            checks, errors;
    int            lo, hold, lo2, hold2;

    aer_array_reset_seq_if aer_if ();

    aer_array_reset_seq #(.PW_WIDTH(PW), .TMO_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .aer       (aer_if.slave),
        .min_pulse (min_pulse),
        .settle    (settle),
        .drain_tmo (drain_tmo),
        .clr_stats (clr_stats),
        .rst_count (rst_count),
        .tmo_flag  (tmo_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count array-reset-low and hold-high cycles until busy drops (bounded)
    task automatic measure(input string tag, output int n_lo, output int n_hold);
        int cyc;
        n_lo = 0; n_hold = 0; cyc = 0;
        while (aer_if.busy === 1'b1 && cyc < 200) begin
            n_lo   += (aer_if.array_rst_n === 1'b0) ? 1 : 0;
            n_hold += (aer_if.readout_hold === 1'b1) ? 1 : 0;
            tick();
            cyc++;
        end
        chk({tag, "_done"}, {31'd0, aer_if.busy}, 32'd0);
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    // One request cycle, then release; returns once the DUT is in DRAIN
    task automatic pulse_req();
        aer_if.rst_req_n = 1'b0;
        tick();
        aer_if.rst_req_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        aer_if.rst_req_n = 1'b1; aer_if.aer_req = 1'b0; aer_if.aer_ack = 1'b0;
        min_pulse = 8'd4; settle = 8'd3; drain_tmo = 8'd0; clr_stats = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_arst",  {31'd0, aer_if.array_rst_n},  32'd1);
        chk("rst_hold",  {31'd0, aer_if.readout_hold}, 32'd0);
        chk("rst_busy",  {31'd0, aer_if.busy},         32'd0);
        chk("rst_count", {30'd0, rst_count},           32'd0);
        chk("rst_tmo",   {31'd0, tmo_flag},            32'd0);
        rst = 1'b0;
        tick();

        // Basic timing: 1 drain + 4 low + 3 guard
        pulse_req();
        chk("t1_busy", {31'd0, aer_if.busy},         32'd1);
        chk("t1_hold", {31'd0, aer_if.readout_hold}, 32'd1);
        chk("t1_arst", {31'd0, aer_if.array_rst_n},  32'd1);
        measure("t1", lo, hold);
        chk("t1_lo",    lo,   32'd4);
        chk("t1_holdn", hold, 32'd8);
        chk("t1_count", {30'd0, rst_count}, 32'd1);
        chk("t1_tmo",   {31'd0, tmo_flag},  32'd0);

        // Drain waits for idle handshake, no timeout when drain_tmo=0
        aer_if.aer_req = 1'b1; aer_if.aer_ack = 1'b1;
        pulse_req();
        repeat (9) tick();
        chk("t2_wait_arst", {31'd0, aer_if.array_rst_n}, 32'd1);
        chk("t2_wait_busy", {31'd0, aer_if.busy},        32'd1);
        aer_if.aer_req = 1'b0; aer_if.aer_ack = 1'b0;
        chk("t2_pre_arst", {31'd0, aer_if.array_rst_n}, 32'd1);
        tick();
        chk("t2_post_arst", {31'd0, aer_if.array_rst_n}, 32'd0);
        measure("t2", lo, hold);
        chk("t2_lo",    lo,   32'd4);
        chk("t2_holdn", hold, 32'd7);
        chk("t2_tmo",   {31'd0, tmo_flag},  32'd0);
        chk("t2_count", {30'd0, rst_count}, 32'd2);

        // Drain timeout after 5 DRAIN cycles with aer_req stuck
        drain_tmo = 8'd5;
        aer_if.aer_req = 1'b1;
        pulse_req();
        lo2 = 0;
        repeat (5) begin
            lo2 += (aer_if.array_rst_n === 1'b1) ? 1 : 0;
            tick();
        end
        chk("t3_drain_cyc", lo2, 32'd5);
        chk("t3_arst",      {31'd0, aer_if.array_rst_n}, 32'd0);
        chk("t3_tmo",       {31'd0, tmo_flag},           32'd1);
        measure("t3", lo, hold);
        chk("t3_lo", lo, 32'd4);
        aer_if.aer_req = 1'b0;
        drain_tmo = 8'd0;
        tick();
        chk("t3_sticky", {31'd0, tmo_flag},  32'd1);
        chk("t3_count",  {30'd0, rst_count}, 32'd3);
        clear_stats();
        chk("t3_clr_tmo",   {31'd0, tmo_flag},  32'd0);
        chk("t3_clr_count", {30'd0, rst_count}, 32'd0);

        // Held request: low sampled 20 edges -> 19 low cycles, one count
        aer_if.rst_req_n = 1'b0;
        tick();
        lo2 = 0;
        repeat (19) begin
            lo2 += (aer_if.array_rst_n === 1'b0) ? 1 : 0;
            tick();
        end
        chk("t4_still_low", {31'd0, aer_if.array_rst_n}, 32'd0);
        aer_if.rst_req_n = 1'b1;
        measure("t4", lo, hold);
        chk("t4_lo",    lo + lo2, 32'd19);
        chk("t4_count", {30'd0, rst_count}, 32'd1);

        // Back-to-back: request during SETTLE restarts after one IDLE cycle
        clear_stats();
        pulse_req();
        repeat (5) tick();
        chk("t5_settle_arst", {31'd0, aer_if.array_rst_n},  32'd1);
        chk("t5_settle_hold", {31'd0, aer_if.readout_hold}, 32'd1);
        aer_if.rst_req_n = 1'b0;
        tick();
        aer_if.rst_req_n = 1'b1;
        tick();
        tick();
        chk("t5_idle_busy",  {31'd0, aer_if.busy},         32'd0);
        chk("t5_idle_hold",  {31'd0, aer_if.readout_hold}, 32'd0);
        chk("t5_idle_count", {30'd0, rst_count},           32'd1);
        tick();
        chk("t5_restart", {31'd0, aer_if.busy}, 32'd1);
        measure("t5", lo, hold);
        chk("t5_lo",    lo,   32'd4);
        chk("t5_holdn", hold, 32'd8);
        chk("t5_count", {30'd0, rst_count}, 32'd2);

        // min_pulse=0 -> 1-cycle pulse, settle=0 -> no guard
        min_pulse = 8'd0; settle = 8'd0;
        pulse_req();
        measure("t6", lo, hold);
        chk("t6_lo",    lo,   32'd1);
        chk("t6_holdn", hold, 32'd2);
        chk("t6_count", {30'd0, rst_count}, 32'd3);

        // Saturation: 5 sequences on a 2-bit counter
        clear_stats();
        min_pulse = 8'd2; settle = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            pulse_req();
            measure("t7", lo, hold);
            chk("t7_count", {30'd0, rst_count}, (i > 3) ? 32'd3 : i);
        end

        // Async reset during ASSERT releases everything at once
        min_pulse = 8'd10; settle = 8'd3;
        pulse_req();
        tick();
        chk("t8_in_assert", {31'd0, aer_if.array_rst_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t8_arst",  {31'd0, aer_if.array_rst_n},  32'd1);
        chk("t8_hold",  {31'd0, aer_if.readout_hold}, 32'd0);
        chk("t8_busy",  {31'd0, aer_if.busy},         32'd0);
        chk("t8_count", {30'd0, rst_count},           32'd0);
        #1 rst = 1'b0;
        tick();
        chk("t8_idle", {31'd0, aer_if.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
